// File: rtl/ad7928_chan_avg.sv
// Per-channel decimating averager for the AD7928 sample stream: eight independent
// accumulators, a per-channel result register bank and a show-ahead output FIFO.
module ad7928_chan_avg #(
    parameter int unsigned AVG_LOG2        = 3,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        core_en,
    input  logic        clear,
    input  logic [11:0] s_adc_data,
    input  logic [2:0]  s_adc_chanel,
    input  logic        s_axis_valid,
    output logic [11:0] m_avg_data,
    output logic [2:0]  m_avg_chanel,
    output logic        m_axis_valid,
    input  logic        m_axis_ready,
    input  logic [2:0]  rd_chanel,
    output logic [11:0] rd_data,
    output logic        overflow
);

    localparam int unsigned AW    = 12 + AVG_LOG2;
    localparam int unsigned CW    = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam int unsigned PW    = FIFO_DEPTH_LOG2;
    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [CW-1:0] LAST_CNT = CW'((1 << AVG_LOG2) - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);

    logic          rst_meta;
    logic          rst_sync;
    logic [AW-1:0] acc     [8];
    logic [CW-1:0] cnt     [8];
    logic [11:0]   avg_reg [8];
    logic [14:0]   mem     [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    logic          accept;
    logic          last;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          drop;
    logic          full;
    logic          empty;
    logic [AW-1:0] sum;
    logic [11:0]   result;
    logic [14:0]   head;

    // Assert asynchronously, release two edges after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    assign accept   = s_axis_valid & core_en & ~clear;
    assign sum      = acc[s_adc_chanel] + AW'(s_adc_data);
    assign result   = 12'(sum >> AVG_LOG2);
    assign last     = (cnt[s_adc_chanel] == LAST_CNT);
    assign push_req = accept & last;
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign pop      = ~empty & m_axis_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            for (int i = 0; i < 8; i++) begin
                acc[i]     <= '0;
                cnt[i]     <= '0;
                avg_reg[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_data <= avg_reg[rd_chanel];
            if (clear) begin
                for (int i = 0; i < 8; i++) begin
                    acc[i] <= '0;
                    cnt[i] <= '0;
                end
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (accept) begin
                    if (last) begin
                        acc[s_adc_chanel]     <= '0;
                        cnt[s_adc_chanel]     <= '0;
                        avg_reg[s_adc_chanel] <= result;
                    end else begin
                        acc[s_adc_chanel] <= sum;
                        cnt[s_adc_chanel] <= cnt[s_adc_chanel] + CW'(1);
                    end
                end
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + (PW + 1)'(1);
                    2'b01:   count <= count - (PW + 1)'(1);
                    default: count <= count;
                endcase
                if (drop) overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {s_adc_chanel, result};
    end

    assign head         = mem[rd_ptr];
    assign m_axis_valid = ~empty;
    assign m_avg_data   = empty ? 12'd0 : head[11:0];
    assign m_avg_chanel = empty ? 3'd0 : head[14:12];

endmodule

// File: tb/tb_ad7928_chan_avg.sv
// Directed bench for ad7928_chan_avg (AVG_LOG2=2, 4-entry FIFO); a monitor process
// checks every handshaked output against a queue of hand-computed expected results.
module tb_ad7928_chan_avg;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        core_en;
    logic        clear;
    logic [11:0] s_adc_data;
    logic [2:0]  s_adc_chanel;
    logic        s_axis_valid;
    logic [11:0] m_avg_data;
    logic [2:0]  m_avg_chanel;
    logic        m_axis_valid;
    logic        m_axis_ready;
    logic [2:0]  rd_chanel;
    logic [11:0] rd_data;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [14:0] exp_q[$];

    ad7928_chan_avg #(
        .AVG_LOG2       (2),
        .FIFO_DEPTH_LOG2(2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .core_en     (core_en),
        .clear       (clear),
        .s_adc_data  (s_adc_data),
        .s_adc_chanel(s_adc_chanel),
        .s_axis_valid(s_axis_valid),
        .m_avg_data  (m_avg_data),
        .m_avg_chanel(m_avg_chanel),
        .m_axis_valid(m_axis_valid),
        .m_axis_ready(m_axis_ready),
        .rd_chanel   (rd_chanel),
        .rd_data     (rd_data),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a handshake is committed at the next posedge.
    always @(negedge clk) begin
        if (m_axis_valid && m_axis_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard: unexpected output ch%0d data %0d",
                         m_avg_chanel, m_avg_data);
            end else begin
                logic [14:0] e;
                e = exp_q.pop_front();
                check("scoreboard chan", int'(m_avg_chanel), int'(e[14:12]));
                check("scoreboard data", int'(m_avg_data), int'(e[11:0]));
            end
        end
    end

    task automatic strobe(input logic [2:0] ch, input logic [11:0] d);
        s_adc_chanel = ch;
        s_adc_data   = d;
        s_axis_valid = 1'b1;
        @(posedge clk);
        #1;
        s_axis_valid = 1'b0;
    endtask

    task automatic block(input logic [2:0] ch, input logic [11:0] d);
        repeat (4) strobe(ch, d);
    endtask

    task automatic expect_out(input logic [2:0] ch, input logic [11:0] d);
        exp_q.push_back({ch, d});
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, " drained"}, exp_q.size(), 0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        core_en      = 1'b1;
        clear        = 1'b0;
        s_adc_data   = '0;
        s_adc_chanel = '0;
        s_axis_valid = 1'b0;
        m_axis_ready = 1'b1;
        rd_chanel    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset valid", int'(m_axis_valid), 0);
        check("reset data", int'(m_avg_data), 0);
        check("reset rd_data", int'(rd_data), 0);
        check("reset overflow", int'(overflow), 0);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Single block on ch3: (100+101+102+103)/4 = 101, valid right after 4th strobe
        expect_out(3'd3, 12'd101);
        strobe(3'd3, 12'd100);
        strobe(3'd3, 12'd101);
        strobe(3'd3, 12'd102);
        check("t1 valid before 4th", int'(m_axis_valid), 0);
        strobe(3'd3, 12'd103);
        check("t1 valid latency", int'(m_axis_valid), 1);
        rd_chanel = 3'd3;
        @(posedge clk);
        #1;
        check("t1 rd_data ch3", int'(rd_data), 101);
        wait_drain("t1");

        // Interleaved ch0 (4095 x4) and ch7 (1,2,3,4 -> 10/4 = 2)
        expect_out(3'd0, 12'd4095);
        expect_out(3'd7, 12'd2);
        for (int i = 0; i < 4; i++) begin
            strobe(3'd0, 12'd4095);
            strobe(3'd7, 12'(i + 1));
        end
        wait_drain("t2");

        // Overflow: five results with ready low, the fifth is dropped
        m_axis_ready = 1'b0;
        expect_out(3'd1, 12'd10);
        expect_out(3'd1, 12'd20);
        expect_out(3'd1, 12'd30);
        expect_out(3'd1, 12'd40);
        block(3'd1, 12'd10);
        block(3'd1, 12'd20);
        block(3'd1, 12'd30);
        block(3'd1, 12'd40);
        check("t3 overflow at full", int'(overflow), 0);
        check("t3 valid at full", int'(m_axis_valid), 1);
        block(3'd1, 12'd50);
        check("t3 overflow after drop", int'(overflow), 1);
        rd_chanel = 3'd1;
        @(posedge clk);
        #1;
        check("t3 rd_data dropped result", int'(rd_data), 50);
        m_axis_ready = 1'b1;
        wait_drain("t3");
        check("t3 valid after drain", int'(m_axis_valid), 0);
        check("t3 overflow sticky", int'(overflow), 1);

        // Full FIFO with simultaneous pop and completing push: no overflow, order kept
        m_axis_ready = 1'b0;
        pulse_clear();
        check("t4 clear overflow", int'(overflow), 0);
        for (int v = 1; v <= 5; v++) expect_out(3'd4, 12'(v));
        for (int v = 1; v <= 4; v++) block(3'd4, 12'(v));
        repeat (3) strobe(3'd4, 12'd5);
        m_axis_ready = 1'b1;
        strobe(3'd4, 12'd5);
        m_axis_ready = 1'b0;
        check("t4 no overflow", int'(overflow), 0);
        check("t4 still valid", int'(m_axis_valid), 1);
        check("t4 head after pop", int'(m_avg_data), 2);
        m_axis_ready = 1'b1;
        wait_drain("t4");
        check("t4 valid after drain", int'(m_axis_valid), 0);

        // clear together with a sample discards the partial block and the sample
        repeat (3) strobe(3'd2, 12'd50);
        clear = 1'b1;
        strobe(3'd2, 12'd50);
        clear = 1'b0;
        check("t5 no output after clear", int'(m_axis_valid), 0);
        rd_chanel = 3'd3;
        @(posedge clk);
        #1;
        check("t5 avg_reg kept by clear", int'(rd_data), 101);
        expect_out(3'd2, 12'd8);
        repeat (3) strobe(3'd2, 12'd8);
        check("t5 valid before 4th", int'(m_axis_valid), 0);
        strobe(3'd2, 12'd8);
        wait_drain("t5");

        // Disabled strobes do not count toward the block
        core_en = 1'b0;
        repeat (3) strobe(3'd5, 12'd40);
        core_en = 1'b1;
        repeat (3) strobe(3'd5, 12'd20);
        check("t6 disabled not counted", int'(m_axis_valid), 0);
        expect_out(3'd5, 12'd20);
        strobe(3'd5, 12'd20);
        wait_drain("t6");

        // Reset mid-block: FIFO entry and partial sums are discarded
        m_axis_ready = 1'b0;
        block(3'd6, 12'd7);
        strobe(3'd6, 12'd100);
        strobe(3'd6, 12'd100);
        rd_chanel = 3'd6;
        @(posedge clk);
        #1;
        check("t7 rd_data before reset", int'(rd_data), 7);
        reset_n = 1'b0;
        #2;
        check("t7 reset valid", int'(m_axis_valid), 0);
        check("t7 reset data", int'(m_avg_data), 0);
        check("t7 reset chan", int'(m_avg_chanel), 0);
        check("t7 reset rd_data", int'(rd_data), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        m_axis_ready = 1'b1;
        expect_out(3'd6, 12'd12);
        block(3'd6, 12'd12);
        wait_drain("t7");
        repeat (2) @(posedge clk);
        #1;
        check("final valid", int'(m_axis_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
